// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// A zero divisor completes on the accepting edge with an all-ones quotient and the dividend as remainder.
module restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] prem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] next_rem;
  logic             last_step;

  // The partial remainder always stays below the divisor, so its top bit is
  // known to be zero and only the shifted/trial values carry WIDTH+1 bits.
  // The dividend register doubles as the quotient register as bits shift in.
  always_comb begin
    shifted  = {prem, shreg[WIDTH-1]};
    trial    = shifted - {1'b0, dsr};
    qbit     = ~trial[WIDTH];
    next_rem = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

  assign last_step = (count == CW'(WIDTH - 1));
  assign busy      = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      shreg       <= '0;
      dsr         <= '0;
      prem        <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (divisor == '0) begin
            done        <= 1'b1;
            div_by_zero <= 1'b1;
            quotient    <= '1;
            remainder   <= dividend;
          end else begin
            shreg <= dividend;
            dsr   <= divisor;
            prem  <= '0;
            count <= '0;
            state <= RUN;
          end
        end
      end else begin
        shreg <= {shreg[WIDTH-2:0], qbit};
        prem  <= next_rem;
        count <= count + 1'b1;
        if (last_step) begin
          quotient    <= {shreg[WIDTH-2:0], qbit};
          remainder   <= next_rem;
          done        <= 1'b1;
          div_by_zero <= 1'b0;
          state       <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases plus a random sweep
// compared against plain integer division.
module tb_restoring_divider;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int checks   = 0;
  int failures = 0;

  restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives a one-cycle start from just after an edge; returns 1ns after the accepting edge.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
  endtask

  // Issues a/b and checks the result; poke_at >= 0 fires a stray start mid-run.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int poke_at);
    int lat = 0;
    int busy_cycles = 0;
    longint recon;
    launch(a, b);
    if (b == '0) begin
      checkOutput("dz_done", 32'(done), 32'd1);
      checkOutput("dz_busy", 32'(busy), 32'd0);
      checkOutput("dz_flag", 32'(div_by_zero), 32'd1);
      checkOutput("dz_quot", 32'(quotient), 32'hFFFF);
      checkOutput("dz_rem", 32'(remainder), 32'(a));
      return;
    end
    checkOutput("accept_done_low", 32'(done), 32'd0);
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      if (lat == poke_at) begin
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'd16);
    checkOutput("busy_cycles", 32'(busy_cycles), 32'd16);
    checkOutput("busy_at_done", 32'(busy), 32'd0);
    checkOutput("quot", 32'(quotient), 32'(a / b));
    checkOutput("rem", 32'(remainder), 32'(a % b));
    checkOutput("dbz_clear", 32'(div_by_zero), 32'd0);
    recon = longint'(quotient) * longint'(b) + longint'(remainder);
    checkOutput("invariant", 32'(recon == longint'(a) && remainder < b), 32'd1);
  endtask

  task automatic idleCycle();
    @(posedge clk); #1;
    checkOutput("pulse_width", 32'(done), 32'd0);
  endtask

  task automatic countDones(input int cycles, input string tag);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checkOutput(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_quot", 32'(quotient), 32'd0);
    checkOutput("rst_rem", 32'(remainder), 32'd0);
    checkOutput("rst_dbz", 32'(div_by_zero), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] directed cases");
    applyStimulus(16'd100, 16'd7, -1);
    checkOutput("q_100_7", 32'(quotient), 32'd14);
    checkOutput("r_100_7", 32'(remainder), 32'd2);
    idleCycle();

    applyStimulus(16'hFFFF, 16'd1, -1);
    applyStimulus(16'hFFFF, 16'hFFFF, -1);
    idleCycle();

    applyStimulus(16'd5, 16'd9, -1);
    idleCycle();
    applyStimulus(16'h1234, 16'd0, -1);
    idleCycle();
    checkOutput("dz_hold_quot", 32'(quotient), 32'hFFFF);

    applyStimulus(16'd1000, 16'd3, 5);
    checkOutput("q_1000_3", 32'(quotient), 32'd333);
    checkOutput("r_1000_3", 32'(remainder), 32'd1);
    countDones(20, "ignored_start_done");

    launch(16'd60000, 16'd7);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_quot", 32'(quotient), 32'd0);
    checkOutput("midrst_rem", 32'(remainder), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    countDones(25, "post_reset_done");
    applyStimulus(16'd60000, 16'd7, -1);
    checkOutput("q_60000_7", 32'(quotient), 32'd8571);
    checkOutput("r_60000_7", 32'(remainder), 32'd3);
    idleCycle();

    $display("[TB] random sweep");
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 7))
        0:       a = '0;
        1:       a = 16'hFFFF;
        default: a = WIDTH'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = 16'd1;
        2:       b = 16'hFFFF;
        3:       b = WIDTH'($urandom_range(1, 15));
        default: b = WIDTH'($urandom);
      endcase
      applyStimulus(a, b, -1);
      if ($urandom_range(0, 1) == 1) idleCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
